// File: rtl/rename_regfile_pkg.sv
// Shared widths for the rename register file and its read ports.
package rename_regfile_pkg;
    localparam int DATA_WID   = 32;
    localparam int REG_ID_WID = 5;
    localparam int ROB_ID_WID = 4;
    localparam int REG_NUM    = 32;
endpackage

// File: rtl/rename_regfile_read_port.sv
// One combinational lookup port: req gating, x0 masking and the optional commit bypass.
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN (forward committing data in the commit cycle).
module regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_WID
) (
    input  logic                  req,
    input  logic [REG_ID_WID-1:0] id,
    input  logic [DATA_WID-1:0]   reg_data,
    input  logic                  reg_busy,
    input  logic [ROB_ID_W-1:0]   reg_tag,
    input  logic                  commit_valid,
    input  logic [REG_ID_WID-1:0] commit_rd,
    input  logic [ROB_ID_W-1:0]   commit_rob_id,
    input  logic [DATA_WID-1:0]   commit_data,
    output logic [DATA_WID-1:0]   data,
    output logic                  busy,
    output logic [ROB_ID_W-1:0]   rob_id
);

    always_comb begin
        data   = '0;
        busy   = 1'b0;
        rob_id = '0;
        if (req && (id != '0)) begin
            data   = reg_data;
            busy   = reg_busy;
            rob_id = reg_tag;
`ifdef REGFILE_COMMIT_BYPASS_EN
            // Only the current producer's commit may be forwarded; rob_id keeps the tag.
            if (commit_valid && (commit_rd == id) && reg_busy && (reg_tag == commit_rob_id)) begin
                data = commit_data;
                busy = 1'b0;
            end
`endif
        end
    end

`ifndef REGFILE_COMMIT_BYPASS_EN
    logic commit_unused;
    assign commit_unused = ^{commit_valid, commit_rd, commit_rob_id, commit_data};
`endif

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/tag rename state.
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN (see regfile_read_port).
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int REG_NUM  = rename_regfile_pkg::REG_NUM,
    parameter int ROB_ID_W = ROB_ID_WID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  rs1_req,
    input  logic [REG_ID_WID-1:0] rs1_id,
    input  logic                  rs2_req,
    input  logic [REG_ID_WID-1:0] rs2_id,
    output logic [DATA_WID-1:0]   rs1_data,
    output logic                  rs1_busy,
    output logic [ROB_ID_W-1:0]   rs1_rob_id,
    output logic [DATA_WID-1:0]   rs2_data,
    output logic                  rs2_busy,
    output logic [ROB_ID_W-1:0]   rs2_rob_id,
    input  logic                  issue_valid,
    input  logic [REG_ID_WID-1:0] issue_rd,
    input  logic [ROB_ID_W-1:0]   issue_rob_id,
    input  logic                  commit_valid,
    input  logic [REG_ID_WID-1:0] commit_rd,
    input  logic [ROB_ID_W-1:0]   commit_rob_id,
    input  logic [DATA_WID-1:0]   commit_data
);

    logic [DATA_WID-1:0] data_q [REG_NUM];
    logic                busy_q [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q  [REG_NUM];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (rollback) begin
                    busy_q[i] <= 1'b0;
                end
                if (commit_valid && (commit_rd == REG_ID_WID'(i))) begin
                    data_q[i] <= commit_data;
                    if (busy_q[i] && (tag_q[i] == commit_rob_id)) begin
                        busy_q[i] <= 1'b0;
                    end
                end
                // Issue is applied last so it overrides a same-cycle commit clear.
                if (issue_valid && !rollback && (issue_rd == REG_ID_WID'(i))) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issue_rob_id;
                end
            end
        end
    end

    regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_rs1_port (
        .req          (rs1_req),
        .id           (rs1_id),
        .reg_data     (data_q[rs1_id]),
        .reg_busy     (busy_q[rs1_id]),
        .reg_tag      (tag_q[rs1_id]),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_rob_id(commit_rob_id),
        .commit_data  (commit_data),
        .data         (rs1_data),
        .busy         (rs1_busy),
        .rob_id       (rs1_rob_id)
    );

    regfile_read_port #(.ROB_ID_W(ROB_ID_W)) u_rs2_port (
        .req          (rs2_req),
        .id           (rs2_id),
        .reg_data     (data_q[rs2_id]),
        .reg_busy     (busy_q[rs2_id]),
        .reg_tag      (tag_q[rs2_id]),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_rob_id(commit_rob_id),
        .commit_data  (commit_data),
        .data         (rs2_data),
        .busy         (rs2_busy),
        .rob_id       (rs2_rob_id)
    );

endmodule

// File: tb/tb_rename_regfile.sv
// Directed self-checking bench for rename_regfile with hand-computed expectations.
module tb_rename_regfile;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        rs1_req, rs2_req;
    logic [4:0]  rs1_id, rs2_id;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_rob_id, rs2_rob_id;
    logic        issue_valid, commit_valid;
    logic [4:0]  issue_rd, commit_rd;
    logic [3:0]  issue_rob_id, commit_rob_id;
    logic [31:0] commit_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .rs1_req(rs1_req), .rs1_id(rs1_id), .rs2_req(rs2_req), .rs2_id(rs2_id),
        .rs1_data(rs1_data), .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
        .rs2_data(rs2_data), .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_data(commit_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rs1(input string tag, input logic [31:0] d, input logic b, input logic [3:0] r);
        check({tag, ".rs1_data"}, rs1_data, d);
        check({tag, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, b});
        check({tag, ".rs1_rob_id"}, {28'd0, rs1_rob_id}, {28'd0, r});
    endtask

    task automatic chk_rs2(input string tag, input logic [31:0] d, input logic b, input logic [3:0] r);
        check({tag, ".rs2_data"}, rs2_data, d);
        check({tag, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, b});
        check({tag, ".rs2_rob_id"}, {28'd0, rs2_rob_id}, {28'd0, r});
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; commit_valid = 1'b0; rollback = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] id);
        rs1_req = 1'b1; rs1_id = id; #1;
    endtask

    task automatic rd2(input logic [4:0] id);
        rs2_req = 1'b1; rs2_id = id; #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] rob);
        issue_valid = 1'b1; issue_rd = rd; issue_rob_id = rob;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] d);
        commit_valid = 1'b1; commit_rd = rd; commit_rob_id = rob; commit_data = d;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        rs1_req = 1'b0; rs1_id = '0; rs2_req = 1'b0; rs2_id = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_data = '0;
        step(); step();
        rst = 1'b0;

        // Reset state and x0 masking
        rd1(5'd5); rd2(5'd0);
        chk_rs1("reset_x5", 32'h0, 1'b0, 4'd0);
        chk_rs2("reset_x0", 32'h0, 1'b0, 4'd0);

        // Issue x3 rob 7: invisible in the same cycle, visible the next
        issue(5'd3, 4'd7); rd1(5'd3);
        chk_rs1("issue_same_cycle", 32'h0, 1'b0, 4'd0);
        step(); idle(); #1;
        chk_rs1("issue_x3", 32'h0, 1'b1, 4'd7);
        rs1_req = 1'b0; #1;
        chk_rs1("req_gated", 32'h0, 1'b0, 4'd0);
        rs1_req = 1'b1;
        commit(5'd3, 4'd7, 32'hDEADBEEF);
        step(); idle(); #1;
        chk_rs1("commit_x3", 32'hDEADBEEF, 1'b0, 4'd7);

        // Stale commit leaves newer producer in place
        issue(5'd4, 4'd2); step();
        issue(5'd4, 4'd5); step(); idle();
        commit(5'd4, 4'd2, 32'h11); step(); idle();
        rd1(5'd4);
        chk_rs1("stale_commit_x4", 32'h11, 1'b1, 4'd5);

        // Same-cycle issue and commit on x6
        issue(5'd6, 4'd1); step(); idle();
        issue(5'd6, 4'd9); commit(5'd6, 4'd1, 32'h22); step(); idle();
        rd2(5'd6);
        chk_rs2("issue_commit_x6", 32'h22, 1'b1, 4'd9);

        // Rollback with same-cycle commit and issue
        issue(5'd1, 4'd3); step();
        issue(5'd2, 4'd4); step(); idle();
        rd1(5'd1); rd2(5'd2);
        chk_rs1("pre_rb_x1", 32'h0, 1'b1, 4'd3);
        chk_rs2("pre_rb_x2", 32'h0, 1'b1, 4'd4);
        rollback = 1'b1; commit(5'd1, 4'd3, 32'h33); issue(5'd8, 4'd6);
        step(); idle(); #1;
        check("rb_x1_data", rs1_data, 32'h33);
        check("rb_x1_busy", {31'd0, rs1_busy}, 32'd0);
        check("rb_x2_busy", {31'd0, rs2_busy}, 32'd0);
        rd1(5'd8);
        check("rb_x8_busy", {31'd0, rs1_busy}, 32'd0);

        // Writes to x0 ignored
        issue(5'd0, 4'd5); commit(5'd0, 4'd5, 32'h44); step(); idle();
        rd1(5'd0);
        chk_rs1("x0_write", 32'h0, 1'b0, 4'd0);

        // rdy low freezes state
        rdy = 1'b0; issue(5'd9, 4'd10); commit(5'd9, 4'd10, 32'h55); step(); idle();
        rdy = 1'b1;
        rd1(5'd9);
        chk_rs1("rdy_hold_x9", 32'h0, 1'b0, 4'd0);

        // Commit bypass (or its absence) on a matching committing register
        issue(5'd12, 4'd8); step(); idle();
        commit(5'd12, 4'd8, 32'h66); rd2(5'd12);
`ifdef REGFILE_COMMIT_BYPASS_EN
        chk_rs2("bypass_x12", 32'h66, 1'b0, 4'd8);
`else
        chk_rs2("nobypass_x12", 32'h0, 1'b1, 4'd8);
`endif
        step(); idle(); #1;
        chk_rs2("post_commit_x12", 32'h66, 1'b0, 4'd8);

        // Reset mid-operation overrides commit and issue
        issue(5'd10, 4'd2); step(); idle();
        rst = 1'b1; commit(5'd10, 4'd2, 32'h77); issue(5'd11, 4'd3); rollback = 1'b1;
        step(); idle(); rst = 1'b0;
        rd1(5'd10); rd2(5'd11);
        chk_rs1("rst_mid_x10", 32'h0, 1'b0, 4'd0);
        chk_rs2("rst_mid_x11", 32'h0, 1'b0, 4'd0);
        rd1(5'd3);
        chk_rs1("rst_mid_x3", 32'h0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
